simon_seq: RTL and testbench
============================

# simon_seq

Parametrised Simon game sequencer. It replaces the single-number Simon core with a memory-backed sequence of up to MAX_LEN entries over NUM_BTN buttons. Each round appends one random entry, plays back the whole sequence, then checks the player's replay. It sits between the `random` generator and the button/display logic of the game top level, and reports turn, level, win and game-over status.

## Interface
- NUM_BTN, 4: number of buttons; BTN_W = max(1, $clog2(NUM_BTN)).
- MAX_LEN, 16: maximum sequence length; reaching it wins the game. LEN_W = $clog2(MAX_LEN+1).
- ON_TICKS, 30: cycles each playback entry is lit.
- OFF_TICKS, 30: gap cycles before each playback entry.
- TIMEOUT_TICKS, 120: idle cycles allowed between player presses.
- clk  in  1: 60 Hz game clock; all logic on the rising edge.
- reset  in  1: synchronous, active-low; sampled on the clk rising edge.
- rand_in  in  BTN_W: random button from `random`. Values ≥ NUM_BTN are reduced modulo NUM_BTN.
- start  in  1: pulse that starts a game; honoured only in IDLE, LOSE or WIN.
- player_num  in  BTN_W: button the player pressed.
- player_pressed  in  1: one-cycle press strobe.
- simon_turn  out  1: high in APPEND/SHOW_OFF/SHOW_ON.
- simon_num  out  BTN_W: entry currently played back.
- simon_pressed  out  1: high only in SHOW_ON.
- level  out  LEN_W: current sequence length.
- game_over  out  1: high in LOSE or WIN.
- win  out  1: high in WIN only.

## Operation
- Storage: seq_mem holds MAX_LEN×BTN_W entries. Registers: len (LEN_W), idx (LEN_W), tick counter sized for max(ON, OFF, TIMEOUT).
- States and transitions:
  - IDLE: on start → APPEND, with len cleared to 0.
  - APPEND: write seq_mem[len] ← rand_in mod NUM_BTN; len ← len+1; idx ← 0; tick ← 0 → SHOW_OFF.
  - SHOW_OFF: after OFF_TICKS cycles → SHOW_ON.
  - SHOW_ON: simon_num = seq_mem[idx]; after ON_TICKS cycles:
    - if idx == len−1 → WAIT_IN with idx ← 0;
    - otherwise idx++ → SHOW_OFF.
  - WAIT_IN: tick counts up and is cleared on every accepted press. On player_pressed:
    - player_num ≠ seq_mem[idx] → LOSE.
    - Match, not last entry → idx++.
    - Match on last entry → WIN if len == MAX_LEN, else APPEND.
    - No press and tick == TIMEOUT_TICKS−1 → LOSE.
  - LOSE/WIN: hold. start → APPEND with len ← 0 (a new game).
- Rules:
  - Earlier entries are never rewritten within a game.
  - player_pressed outside WAIT_IN is ignored.
  - start is ignored in APPEND/SHOW/WAIT_IN.
- Outputs are Moore-decoded from registered state and registers.
  - simon_num is 0 outside SHOW_ON.
  - level = len.

## Timing
- Reset values (reset low at an edge): state IDLE, len 0, idx 0, tick 0. Outputs: simon_turn 0, simon_num 0, simon_pressed 0, level 0, game_over 0, win 0. Memory contents are don't-care.
- Reset mid-game takes effect at the next edge, from any state.
- Start latency:
  - start sampled at edge E → APPEND after E.
  - SHOW_OFF after E+1.
  - simon_pressed rises after edge E+1+OFF_TICKS and stays high exactly ON_TICKS cycles.
- One round of playback lasts len×(OFF_TICKS+ON_TICKS) cycles, then WAIT_IN.
- Last correct press at edge P → APPEND after P. Playback of the new round follows with the same latency as start.
- A press and timeout in the same cycle: the press takes priority.
- Timeout fires exactly TIMEOUT_TICKS cycles after entering WAIT_IN or after the last accepted press.
- len never exceeds MAX_LEN. idx never exceeds len−1.

## Configuration
- SIMON_SPEEDUP_EN defined: while len > MAX_LEN/2 (integer division), SHOW_ON and SHOW_OFF each use max(1, TICKS/2) cycles.
- SIMON_SPEEDUP_EN undefined: ON_TICKS and OFF_TICKS are used unchanged at every level.

## Test plan
Unless stated otherwise, the bench uses NUM_BTN=4, MAX_LEN=3, ON=2, OFF=2, TIMEOUT=5.
- Reset: reset=0 for 2 cycles → all outputs 0 and state IDLE. Then start, followed by reset=0 mid-SHOW_ON → back to IDLE with level 0 next edge.
- Round 1: rand_in=2, start at edge 0 →
  - level=1, simon_turn=1;
  - simon_pressed=1 with simon_num=2 after edges 3–4;
  - WAIT_IN after edge 5 (simon_turn=0).
- Full win: rand_in sequence 2,0,3 and correct replays each round → win=1, game_over=1, level=3 after the final press. A later start restarts with level=1.
- Wrong press: in round 2 (seq 2,0), press 2 then 1 → LOSE: game_over=1, win=0, level=2.
- Timeout: enter WAIT_IN with no press → game_over=1 exactly 5 cycles later. A press on cycle 5 instead → accepted, no LOSE.
- Speedup: MAX_LEN=4, ON=4, OFF=4, macro defined → rounds 3–4 show 2-cycle on/off. With the macro undefined → 4-cycle on/off.

Source files
------------

// File: rtl/simon_seq.sv
// rtl/simon_seq.sv - Memory-backed Simon sequencer (append, play back, check replay).
// Optional SIMON_SPEEDUP_EN: halves playback on/off time once len exceeds MAX_LEN/2.
module simon_seq #(
  parameter int NUM_BTN       = 4,
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 30,
  parameter int TIMEOUT_TICKS = 120,
  localparam int BTN_W        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  localparam int LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] rand_in,
  input  logic             start,
  input  logic [BTN_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LEN_W-1:0] level,
  output logic             game_over,
  output logic             win
);

  localparam int ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TICK_MAX = (ON_TICKS > OFF_TICKS)
                            ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                            : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
  localparam int TICK_W   = $clog2(TICK_MAX + 1);

  localparam logic [BTN_W:0]   NUM_BTN_W = (BTN_W + 1)'(NUM_BTN);
  localparam logic [BTN_W-1:0] NUM_BTN_T = BTN_W'(NUM_BTN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_SHOW_OFF, S_SHOW_ON, S_WAIT_IN, S_LOSE, S_WIN
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [TICK_W-1:0] tick_q;
  logic [BTN_W-1:0]  seq_mem [MAX_LEN];

  logic [BTN_W-1:0]  rand_mod;
  logic [BTN_W-1:0]  cur_entry;
  logic              last_entry;
  logic [TICK_W-1:0] on_last;
  logic [TICK_W-1:0] off_last;

  // rand_in is always below 2*NUM_BTN, so one conditional subtract is a full modulo
  assign rand_mod   = ({1'b0, rand_in} >= NUM_BTN_W) ? (rand_in - NUM_BTN_T) : rand_in;
  assign cur_entry  = seq_mem[idx_q[ADDR_W-1:0]];
  assign last_entry = (idx_q == len_q - LEN_W'(1));

`ifdef SIMON_SPEEDUP_EN
  localparam int ON_FAST  = (ON_TICKS / 2 >= 1) ? ON_TICKS / 2 : 1;
  localparam int OFF_FAST = (OFF_TICKS / 2 >= 1) ? OFF_TICKS / 2 : 1;
  logic fast;
  assign fast     = (len_q > LEN_W'(MAX_LEN / 2));
  assign on_last  = fast ? TICK_W'(ON_FAST - 1) : TICK_W'(ON_TICKS - 1);
  assign off_last = fast ? TICK_W'(OFF_FAST - 1) : TICK_W'(OFF_TICKS - 1);
`else
  assign on_last  = TICK_W'(ON_TICKS - 1);
  assign off_last = TICK_W'(OFF_TICKS - 1);
`endif

  always_ff @(posedge clk) begin
    if (state_q == S_APPEND) begin
      seq_mem[len_q[ADDR_W-1:0]] <= rand_mod;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOSE, S_WIN: begin
          if (start) begin
            state_q <= S_APPEND;
            len_q   <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
          end
        end
        S_APPEND: begin
          len_q   <= len_q + LEN_W'(1);
          idx_q   <= '0;
          tick_q  <= '0;
          state_q <= S_SHOW_OFF;
        end
        S_SHOW_OFF: begin
          if (tick_q == off_last) begin
            tick_q  <= '0;
            state_q <= S_SHOW_ON;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        S_SHOW_ON: begin
          if (tick_q == on_last) begin
            tick_q <= '0;
            if (last_entry) begin
              idx_q   <= '0;
              state_q <= S_WAIT_IN;
            end else begin
              idx_q   <= idx_q + LEN_W'(1);
              state_q <= S_SHOW_OFF;
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        S_WAIT_IN: begin
          // a press in the timeout cycle wins over the timeout
          if (player_pressed) begin
            tick_q <= '0;
            if (player_num != cur_entry) begin
              state_q <= S_LOSE;
            end else if (last_entry) begin
              state_q <= (len_q == MAX_LEN_L) ? S_WIN : S_APPEND;
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end else if (tick_q == TICK_W'(TIMEOUT_TICKS - 1)) begin
            state_q <= S_LOSE;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign simon_turn    = (state_q == S_APPEND) || (state_q == S_SHOW_OFF) || (state_q == S_SHOW_ON);
  assign simon_pressed = (state_q == S_SHOW_ON);
  assign simon_num     = simon_pressed ? cur_entry : '0;
  assign level         = len_q;
  assign game_over     = (state_q == S_LOSE) || (state_q == S_WIN);
  assign win           = (state_q == S_WIN);

endmodule

// File: tb/tb_simon_seq.sv
// tb/tb_simon_seq.sv - Table-driven bench for simon_seq plus multi-cycle corner sequences.
module tb_simon_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rand_in = '0;
  logic [1:0] player_num = '0;
  logic       player_pressed = 1'b0;

  logic       turn, spr, go, win;
  logic [1:0] num, level;
  logic       f_turn, f_spr, f_go, f_win;
  logic [1:0] f_num;
  logic [2:0] f_level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simon_seq #(.NUM_BTN(4), .MAX_LEN(3), .ON_TICKS(2), .OFF_TICKS(2), .TIMEOUT_TICKS(5)) u_dut (
    .clk(clk), .reset(rst_n), .rand_in(rand_in), .start(start),
    .player_num(player_num), .player_pressed(player_pressed),
    .simon_turn(turn), .simon_num(num), .simon_pressed(spr),
    .level(level), .game_over(go), .win(win)
  );

  simon_seq #(.NUM_BTN(4), .MAX_LEN(4), .ON_TICKS(4), .OFF_TICKS(4), .TIMEOUT_TICKS(120)) u_fast (
    .clk(clk), .reset(rst_n), .rand_in(rand_in), .start(start),
    .player_num(player_num), .player_pressed(player_pressed),
    .simon_turn(f_turn), .simon_num(f_num), .simon_pressed(f_spr),
    .level(f_level), .game_over(f_go), .win(f_win)
  );

  // outputs packed as {turn, num, pressed, level, game_over, win}
  logic [7:0] dut_out;
  assign dut_out = {turn, num, spr, level, go, win};

  typedef struct {
    logic       rn;
    logic       st;
    logic [1:0] rnd;
    logic [1:0] pn;
    logic       pr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, st, input logic [1:0] rnd, pn, input logic pr,
                     input logic t, input logic [1:0] n, input logic s,
                     input logic [1:0] l, input logic g, w);
    vec_t v;
    v.rn = rn; v.st = st; v.rnd = rnd; v.pn = pn; v.pr = pr;
    v.exp = {t, n, s, l, g, w};
    vecs.push_back(v);
  endtask

  task automatic step(input logic rn, st, input logic [1:0] rnd, pn, input logic pr);
    @(negedge clk);
    rst_n = rn; start = st; rand_in = rnd; player_num = pn; player_pressed = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic [1:0] fseq [4];
  logic [1:0] cur_rand;
  int cyc, on_cnt, exp_t;

  initial begin
    // reset, round 1, full win, restart, wrong press in round 1
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,2,0,0, 1,0,0,0,0,0);
    add(1,0,2,0,1, 1,0,0,1,0,0);
    add(1,0,2,0,0, 1,0,0,1,0,0);
    add(1,1,2,0,0, 1,2,1,1,0,0);
    add(1,0,2,0,0, 1,2,1,1,0,0);
    add(1,0,2,0,0, 0,0,0,1,0,0);
    add(1,0,0,2,1, 1,0,0,1,0,0);
    add(1,0,0,0,0, 1,0,0,2,0,0);
    add(1,0,0,0,0, 1,0,0,2,0,0);
    add(1,0,0,0,0, 1,2,1,2,0,0);
    add(1,0,0,0,0, 1,2,1,2,0,0);
    add(1,0,0,0,0, 1,0,0,2,0,0);
    add(1,0,0,0,0, 1,0,0,2,0,0);
    add(1,0,0,0,0, 1,0,1,2,0,0);
    add(1,0,0,0,0, 1,0,1,2,0,0);
    add(1,0,0,0,0, 0,0,0,2,0,0);
    add(1,0,3,2,1, 0,0,0,2,0,0);
    add(1,0,3,0,1, 1,0,0,2,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,2,1,3,0,0);
    add(1,0,3,0,0, 1,2,1,3,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,0,1,3,0,0);
    add(1,0,3,0,0, 1,0,1,3,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,0,0,3,0,0);
    add(1,0,3,0,0, 1,3,1,3,0,0);
    add(1,0,3,0,0, 1,3,1,3,0,0);
    add(1,0,3,0,0, 0,0,0,3,0,0);
    add(1,0,3,2,1, 0,0,0,3,0,0);
    add(1,0,3,0,1, 0,0,0,3,0,0);
    add(1,0,3,3,1, 0,0,0,3,1,1);
    add(1,0,3,1,1, 0,0,0,3,1,1);
    add(1,1,1,0,0, 1,0,0,0,0,0);
    add(1,0,1,0,0, 1,0,0,1,0,0);
    add(1,0,1,0,0, 1,0,0,1,0,0);
    add(1,0,1,0,0, 1,1,1,1,0,0);
    add(1,0,1,0,0, 1,1,1,1,0,0);
    add(1,0,1,0,0, 0,0,0,1,0,0);
    add(1,0,1,3,1, 0,0,0,1,1,0);
    add(1,0,1,0,0, 0,0,0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rn, vecs[i].st, vecs[i].rnd, vecs[i].pn, vecs[i].pr);
      chk($sformatf("vec%0d", i), 32'(dut_out), 32'(vecs[i].exp));
    end

    // reset in the middle of SHOW_ON
    step(0,0,0,0,0);
    step(1,1,2,0,0);
    step(1,0,2,0,0);
    repeat (3) step(1,0,2,0,0);
    chk("mid_reset_show_on", 32'(spr), 32'd1);
    step(0,0,2,0,0);
    chk("mid_reset_outputs", 32'(dut_out), 32'd0);
    step(1,0,2,0,0);
    chk("mid_reset_idle", 32'(dut_out), 32'd0);

    // wrong press in round 2: sequence 2,0, replay 2 then 1
    step(1,1,2,0,0);
    step(1,0,2,0,0);
    repeat (4) step(1,0,2,0,0);
    step(1,0,0,2,1);
    step(1,0,0,0,0);
    repeat (8) step(1,0,0,0,0);
    chk("wrong_wait_in", 32'({turn, level}), 32'({1'b0, 2'd2}));
    step(1,0,0,2,1);
    chk("wrong_first_ok", 32'(go), 32'd0);
    step(1,0,0,1,1);
    chk("wrong_lose", 32'({go, win, level}), 32'({1'b1, 1'b0, 2'd2}));

    // timeout exactly five idle cycles after entering WAIT_IN
    step(0,0,0,0,0);
    step(1,1,2,0,0);
    step(1,0,2,0,0);
    repeat (4) step(1,0,2,0,0);
    repeat (4) step(1,0,2,0,0);
    chk("timeout_not_yet", 32'(go), 32'd0);
    step(1,0,2,0,0);
    chk("timeout_fires", 32'({go, win, level}), 32'({1'b1, 1'b0, 2'd1}));

    // press in the timeout cycle is accepted
    step(0,0,0,0,0);
    step(1,1,2,0,0);
    step(1,0,2,0,0);
    repeat (4) step(1,0,2,0,0);
    repeat (4) step(1,0,2,0,0);
    step(1,0,2,2,1);
    chk("press_beats_timeout", 32'({turn, go}), 32'({1'b1, 1'b0}));
    step(1,0,2,0,0);
    chk("press_beats_timeout_lvl", 32'(level), 32'd2);

    // playback timing of the MAX_LEN=4, 4-tick instance, with and without speedup
    fseq[0] = 2'd1; fseq[1] = 2'd3; fseq[2] = 2'd0; fseq[3] = 2'd2;
    cur_rand = fseq[0];
    step(0,0,0,0,0);
    step(1,1,cur_rand,0,0);
    for (int l = 1; l <= 4; l++) begin
`ifdef SIMON_SPEEDUP_EN
      exp_t = (l > 2) ? 2 : 4;
`else
      exp_t = 4;
`endif
      cyc = 0;
      on_cnt = 0;
      do begin
        step(1,0,cur_rand,0,0);
        cyc++;
        if (f_spr) on_cnt++;
      end while (f_turn && cyc < 200);
      chk($sformatf("fast_round%0d_cycles", l), 32'(cyc), 32'(1 + 2 * exp_t * l));
      chk($sformatf("fast_round%0d_on", l), 32'(on_cnt), 32'(exp_t * l));
      for (int k = 0; k < l; k++) begin
        if (k == l - 1 && l < 4) cur_rand = fseq[l];
        step(1,0,cur_rand,fseq[k],1);
      end
      if (l < 4) chk($sformatf("fast_round%0d_next", l), 32'({f_turn, f_go, f_level}), 32'({1'b1, 1'b0, 3'(l)}));
      else chk("fast_win", 32'({f_win, f_go, f_level}), 32'({1'b1, 1'b1, 3'd4}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
